cva6_mem_tid_tracker: RTL and testbench
=======================================

// Module: cva6_mem_tid_tracker
// PURPOSE
// Memory-side transaction-ID allocator/tracker between the HPDcache miss/uncached request port and the AXI adapter.
// Hands out a unique MemTid per outgoing request, holds it until the final response beat returns, flags
// responses carrying unallocated IDs, and drains all traffic on flush (fence.i / sfence).
// PARAMETERS
// TidWidth       4     memory transaction ID width (= MemTidWidth)
// NrOutstanding  8     max in-flight requests; must be <= 2**TidWidth, checked by elaboration assertion
// TimeoutCycles  1024  age limit per entry; used only when CVA6_MEM_TID_TIMEOUT_EN is defined
// PORTS
// clk_i              in   1                       clock
// rst_ni             in   1                       asynchronous reset, active-low
// req_valid_i        in   1                       requester wants a TID
// req_ready_o        out  1                       TID available; request accepted when valid&&ready
// req_tid_o          out  TidWidth                allocated TID, meaningful when req_ready_o=1
// resp_valid_i       in   1                       response beat from memory
// resp_tid_i         in   TidWidth                TID of the response beat
// resp_last_i        in   1                       final beat of the response
// resp_ready_o       out  1                       tied 1 (tracker never back-pressures responses)
// flush_i            in   1                       request to drain all outstanding transactions
// flush_done_o       out  1                       1-cycle pulse when the drain is complete
// outstanding_o      out  $clog2(NrOutstanding+1) number of allocated TIDs
// err_unexpected_o   out  1                       1-cycle pulse: last beat for an unallocated TID
// err_tid_o          out  TidWidth                offending TID, held until the next error
// timeout_o          out  1                       1-cycle pulse on entry timeout (macro only; else tied 0)
// BEHAVIOUR
// - Reset: busy bitmap all 0, outstanding_o=0, req_ready_o=1 (FSM IDLE, not full), req_tid_o=0,
//   flush_done_o=0, err_unexpected_o=0, err_tid_o=0, timeout_o=0.
// - Allocation: req_tid_o = lowest-index free TID in [0,NrOutstanding). Combinational from the registered bitmap.
//   The bit is set on the clock edge of the valid&&ready handshake. No added request latency.
// - req_ready_o = (FSM==IDLE) && !full; full when outstanding_o==NrOutstanding.
// - Free: resp_valid_i && resp_last_i && busy[resp_tid_i] clears the bit at the next edge. Non-last beats only
//   pass through; they change no state.
// - resp_last_i for a non-busy TID, or a TID >= NrOutstanding: err_unexpected_o pulses next cycle,
//   err_tid_o <= resp_tid_i, bitmap unchanged.
// - Same-cycle alloc+free: allocation uses the pre-edge bitmap, so the TID being freed is not reissued in
//   that cycle. outstanding_o stays unchanged. At full, a same-cycle free does not raise req_ready_o until
//   the next cycle.
// - outstanding_o is a registered counter: +1 on alloc, -1 on free, net 0 on both; never wraps
//   (assertion: no alloc when full, no free when 0).
// - FSM:
//   IDLE  -> DRAIN when flush_i=1.
//   DRAIN: req_ready_o=0, responses still retire; DRAIN -> DONE when outstanding_o==0
//   (already 0 on entry -> DONE on the next cycle).
//   DONE: flush_done_o=1 for one cycle; DONE -> IDLE. flush_i held high in IDLE restarts the drain.
// - Reset mid-drain: returns to IDLE with an empty bitmap; no flush_done_o pulse.
// CONFIGURATION
// - CVA6_MEM_TID_TIMEOUT_EN defined: one age counter per entry, cleared on alloc, +1 per cycle while busy,
//   saturating. When it reaches TimeoutCycles-1: timeout_o pulses once, err_tid_o <= that TID, entry stays busy
//   (no forced free). Simultaneous timeouts are reported lowest TID first, one per cycle.
// - Not defined: no counters instantiated, timeout_o tied 0, TimeoutCycles ignored.
// TESTING
// - After reset, 8 back-to-back requests -> TIDs 0..7 in order; cycle 9 req_ready_o=0, outstanding_o=8.
// - Full; last beat TID 3 -> next cycle req_ready_o=1, req_tid_o=3, outstanding_o=7.
// - outstanding_o=2 (TIDs 0,1); same cycle alloc + free TID 0 -> alloc gets TID 2, outstanding_o stays 2.
// - Last beat for unallocated TID 5 -> err_unexpected_o pulses once, err_tid_o=5, outstanding_o unchanged;
//   non-last beat TID 5 -> no error.
// - TIDs 0,1 busy, flush_i 1 cycle -> req_ready_o=0; retire 1 then 0 -> flush_done_o pulses the cycle after
//   the final free, then IDLE with req_ready_o=1.
// - Macro on, TimeoutCycles=16: allocate TID 0, no response -> timeout_o pulses exactly once, 15 cycles
//   after alloc; err_tid_o=0.

Source files
------------

// File: rtl/cva6_mem_tid_tracker.sv
// Memory-side transaction-ID allocator/tracker with flush drain and unexpected-response detection.
// Optional per-entry age timeout enabled by defining CVA6_MEM_TID_TIMEOUT_EN.
module cva6_mem_tid_tracker #(
  parameter int unsigned TidWidth      = 4,
  parameter int unsigned NrOutstanding = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  output logic [TidWidth-1:0]                  req_tid_o,
  input  logic                                 resp_valid_i,
  input  logic [TidWidth-1:0]                  resp_tid_i,
  input  logic                                 resp_last_i,
  output logic                                 resp_ready_o,
  input  logic                                 flush_i,
  output logic                                 flush_done_o,
  output logic [$clog2(NrOutstanding+1)-1:0]   outstanding_o,
  output logic                                 err_unexpected_o,
  output logic [TidWidth-1:0]                  err_tid_o,
  output logic                                 timeout_o
);

  localparam int unsigned NrTids   = 1 << TidWidth;
  localparam int unsigned CntWidth = $clog2(NrOutstanding + 1);

  if (NrOutstanding > NrTids || NrOutstanding == 0 || TimeoutCycles == 0) begin : gen_bad_cfg
    $error("cva6_mem_tid_tracker: NrOutstanding must be in [1, 2**TidWidth] and TimeoutCycles > 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_e;

  state_e                   state_reg, state_next;
  logic [NrOutstanding-1:0] busy_reg, busy_next;
  logic [NrTids-1:0]        busy_ext;
  logic [CntWidth-1:0]      count_reg, count_next;
  logic [TidWidth-1:0]      alloc_tid;
  logic                     full, alloc, free, resp_last, err_next;
  logic                     err_unexpected_reg;
  logic [TidWidth-1:0]      err_tid_reg;
  logic                     timeout_fire;
  logic [TidWidth-1:0]      timeout_tid;

  genvar gi;

  // Zero-extended view so any resp_tid_i indexes safely; IDs past NrOutstanding read as free.
  assign busy_ext = NrTids'(busy_reg);

  always_comb begin
    alloc_tid = '0;
    for (int i = int'(NrOutstanding) - 1; i >= 0; i--) begin
      if (!busy_reg[i]) alloc_tid = TidWidth'(i);
    end
  end

  assign full         = (count_reg == CntWidth'(NrOutstanding));
  assign req_ready_o  = (state_reg == IDLE) && !full;
  assign req_tid_o    = alloc_tid;
  assign alloc        = req_valid_i && req_ready_o;
  assign resp_last    = resp_valid_i && resp_last_i;
  assign free         = resp_last && busy_ext[resp_tid_i];
  assign err_next     = resp_last && !busy_ext[resp_tid_i];
  assign resp_ready_o = 1'b1;

  // Allocation picks from the pre-edge bitmap, so a freed ID is never reissued in the same cycle.
  for (gi = 0; gi < NrOutstanding; gi++) begin : gen_busy
    assign busy_next[gi] = (busy_reg[gi] || (alloc && alloc_tid == TidWidth'(gi)))
                           && !(free && resp_tid_i == TidWidth'(gi));
  end

  always_comb begin
    count_next = count_reg;
    if (alloc && !free) begin
      count_next = count_reg + 1'b1;
    end else if (free && !alloc) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (flush_i) state_next = DRAIN;
      DRAIN:   if (count_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef CVA6_MEM_TID_TIMEOUT_EN
  localparam int unsigned AgeWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [AgeWidth-1:0] AgeMax = AgeWidth'(TimeoutCycles - 1);

  logic [NrOutstanding-1:0] timed_out, report_onehot;

  for (gi = 0; gi < NrOutstanding; gi++) begin : gen_age
    logic [AgeWidth-1:0] age_reg;
    logic                reported_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        age_reg      <= '0;
        reported_reg <= 1'b0;
      end else if (alloc && alloc_tid == TidWidth'(gi)) begin
        age_reg      <= '0;
        reported_reg <= 1'b0;
      end else if (busy_reg[gi]) begin
        if (age_reg != AgeMax) age_reg <= age_reg + 1'b1;
        if (report_onehot[gi]) reported_reg <= 1'b1;
      end
    end

    assign timed_out[gi] = busy_reg[gi] && (age_reg == AgeMax) && !reported_reg;
  end

  // Only the lowest pending timeout is reported each cycle; the rest wait their turn.
  assign report_onehot = timed_out & (~timed_out + 1'b1);
  assign timeout_fire  = |timed_out;

  always_comb begin
    timeout_tid = '0;
    for (int i = int'(NrOutstanding) - 1; i >= 0; i--) begin
      if (timed_out[i]) timeout_tid = TidWidth'(i);
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_tid  = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg          <= IDLE;
      busy_reg           <= '0;
      count_reg          <= '0;
      err_unexpected_reg <= 1'b0;
      err_tid_reg        <= '0;
    end else begin
      state_reg          <= state_next;
      busy_reg           <= busy_next;
      count_reg          <= count_next;
      err_unexpected_reg <= err_next;
      // An unexpected response takes the error-ID register over a concurrent timeout report.
      if (err_next) begin
        err_tid_reg <= resp_tid_i;
      end else if (timeout_fire) begin
        err_tid_reg <= timeout_tid;
      end
    end
  end

  assign flush_done_o     = (state_reg == DONE);
  assign outstanding_o    = count_reg;
  assign err_unexpected_o = err_unexpected_reg;
  assign err_tid_o        = err_tid_reg;
  assign timeout_o        = timeout_fire;

  a_no_alloc_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(alloc && full));
  a_no_free_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(free && !alloc && count_reg == '0));

endmodule

// File: tb/tb_cva6_mem_tid_tracker.sv
// Table-driven bench for cva6_mem_tid_tracker with an error-ID scoreboard and hand-written
// flush, timeout and reset-mid-drain sequences.
module tb_cva6_mem_tid_tracker;
  localparam int TW = 4;
  localparam int NO = 8;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [TW-1:0] req_tid_o;
  logic          resp_valid_i = 1'b0;
  logic [TW-1:0] resp_tid_i = '0;
  logic          resp_last_i = 1'b0;
  logic          resp_ready_o;
  logic          flush_i = 1'b0;
  logic          flush_done_o;
  logic [3:0]    outstanding_o;
  logic          err_unexpected_o;
  logic [TW-1:0] err_tid_o;
  logic          timeout_o;

  cva6_mem_tid_tracker #(
    .TidWidth      (TW),
    .NrOutstanding (NO),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_tid_o        (req_tid_o),
    .resp_valid_i     (resp_valid_i),
    .resp_tid_i       (resp_tid_i),
    .resp_last_i      (resp_last_i),
    .resp_ready_o     (resp_ready_o),
    .flush_i          (flush_i),
    .flush_done_o     (flush_done_o),
    .outstanding_o    (outstanding_o),
    .err_unexpected_o (err_unexpected_o),
    .err_tid_o        (err_tid_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rv;
    logic       pv;
    logic [3:0] pt;
    logic       pl;
    logic       fl;
    logic       ready;
    logic [3:0] tid;
    logic [3:0] outs;
    logic       err;
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [TW-1:0] err_q[$];
  vec_t          vecs[34];

  function automatic vec_t mk(input logic rv, input logic pv, input logic [3:0] pt, input logic pl,
                              input logic fl, input logic ready, input logic [3:0] tid,
                              input logic [3:0] outs, input logic err);
    vec_t v;
    v.rv = rv; v.pv = pv; v.pt = pt; v.pl = pl; v.fl = fl;
    v.ready = ready; v.tid = tid; v.outs = outs; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic pv, input logic [3:0] pt, input logic pl,
                       input logic fl);
    req_valid_i  = rv;
    resp_valid_i = pv;
    resp_tid_i   = pt;
    resp_last_i  = pl;
    flush_i      = fl;
  endtask

  // Advance one clock and retire any error pulse against the scoreboard.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (err_unexpected_o) begin
      if (err_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL err_spurious: got pulse with tid %0d, expected no pulse", err_tid_o);
      end else begin
        check("err_tid", err_tid_o, err_q.pop_front());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int pulse_at;

    for (int i = 0; i < 8; i++) vecs[i] = mk(1, 0, 0, 0, 0, 1, 4'(i), 4'(i + 1), 0);
    vecs[8]  = mk(1, 0, 0,  0, 0, 0, 0, 8, 0);
    vecs[9]  = mk(1, 1, 3,  1, 0, 0, 0, 7, 0);
    vecs[10] = mk(0, 0, 0,  0, 0, 1, 3, 7, 0);
    vecs[11] = mk(0, 1, 5,  0, 0, 1, 3, 7, 0);
    vecs[12] = mk(0, 1, 5,  1, 0, 1, 3, 6, 0);
    vecs[13] = mk(0, 1, 5,  1, 0, 1, 3, 6, 1);
    vecs[14] = mk(0, 1, 5,  0, 0, 1, 3, 6, 0);
    vecs[15] = mk(0, 1, 12, 1, 0, 1, 3, 6, 1);
    vecs[16] = mk(1, 1, 0,  1, 0, 1, 3, 6, 0);
    vecs[17] = mk(1, 0, 0,  0, 0, 1, 0, 7, 0);
    vecs[18] = mk(1, 0, 0,  0, 0, 1, 5, 8, 0);
    vecs[19] = mk(0, 0, 0,  0, 0, 0, 0, 8, 0);
    for (int k = 0; k < 8; k++) vecs[20 + k] = mk(0, 1, 4'(k), 1, 0, (k != 0), 0, 4'(7 - k), 0);
    vecs[28] = mk(1, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[29] = mk(1, 0, 0, 0, 0, 1, 1, 2, 0);
    vecs[30] = mk(1, 1, 0, 1, 0, 1, 2, 2, 0);
    vecs[31] = mk(0, 0, 0, 0, 0, 1, 0, 2, 0);
    vecs[32] = mk(0, 1, 1, 1, 0, 1, 0, 1, 0);
    vecs[33] = mk(0, 1, 2, 1, 0, 1, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_tid", req_tid_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_flush_done", flush_done_o, 0);
    check("rst_err", err_unexpected_o, 0);
    check("rst_err_tid", err_tid_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("resp_ready", resp_ready_o, 1);
    rst_ni = 1'b1;
    tick();

    // Table-driven allocation / free / error vectors
    for (int i = 0; i < 34; i++) begin
      drive(vecs[i].rv, vecs[i].pv, vecs[i].pt, vecs[i].pl, vecs[i].fl);
      #1;
      check($sformatf("v%0d_ready", i), req_ready_o, vecs[i].ready);
      if (vecs[i].ready) check($sformatf("v%0d_tid", i), req_tid_o, vecs[i].tid);
      if (vecs[i].err) err_q.push_back(vecs[i].pt);
      tick();
      check($sformatf("v%0d_outstanding", i), outstanding_o, vecs[i].outs);
      check($sformatf("v%0d_err", i), err_unexpected_o, vecs[i].err);
    end
    drive(0, 0, 0, 0, 0);

    // Flush with TIDs 0,1 outstanding
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); tick();
    check("fl_outstanding", outstanding_o, 2);
    drive(0, 0, 0, 0, 1);
    #1;
    check("fl_ready_idle", req_ready_o, 1);
    tick();
    check("fl_drain_ready", req_ready_o, 0);
    check("fl_drain_done", flush_done_o, 0);
    drive(1, 1, 1, 1, 0);
    #1;
    check("fl_drain_noreq", req_ready_o, 0);
    tick();
    check("fl_free1_out", outstanding_o, 1);
    check("fl_free1_done", flush_done_o, 0);
    drive(0, 1, 0, 1, 0); tick();
    check("fl_free0_out", outstanding_o, 0);
    check("fl_free0_done", flush_done_o, 0);
    drive(0, 0, 0, 0, 0); tick();
    check("fl_done_pulse", flush_done_o, 1);
    check("fl_done_ready", req_ready_o, 0);
    tick();
    check("fl_after_done", flush_done_o, 0);
    check("fl_after_ready", req_ready_o, 1);
    check("fl_after_tid", req_tid_o, 0);

    // Flush with nothing outstanding
    drive(0, 0, 0, 0, 1); tick();
    check("fe_drain_done", flush_done_o, 0);
    check("fe_drain_ready", req_ready_o, 0);
    drive(0, 0, 0, 0, 0); tick();
    check("fe_done_pulse", flush_done_o, 1);
    tick();
    check("fe_idle_done", flush_done_o, 0);
    check("fe_idle_ready", req_ready_o, 1);

    // Timeout window on a single entry
    drive(1, 0, 0, 0, 0);
    #1;
    check("to_alloc_tid", req_tid_o, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    pulses = 0;
    pulse_at = -1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (timeout_o) begin
        pulses++;
        pulse_at = k;
      end
    end
`ifdef CVA6_MEM_TID_TIMEOUT_EN
    check("to_pulses", pulses, 1);
    check("to_pulse_cycle", pulse_at, 15);
    check("to_err_tid", err_tid_o, 0);
`else
    check("to_pulses", pulses, 0);
    check("to_err_tid_held", err_tid_o, 12);
`endif
    check("to_still_busy", outstanding_o, 1);
    drive(0, 1, 0, 1, 0); tick();
    check("to_freed", outstanding_o, 0);

    // Reset in the middle of a drain
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1); tick();
    check("rd_drain_ready", req_ready_o, 0);
    drive(0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rd_async_out", outstanding_o, 0);
    check("rd_async_ready", req_ready_o, 1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    check("rd_done", flush_done_o, 0);
    check("rd_ready", req_ready_o, 1);
    check("rd_tid", req_tid_o, 0);
    check("rd_err_tid", err_tid_o, 0);
    tick();
    check("rd_done2", flush_done_o, 0);

    check("err_queue_empty", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
